// File: rtl/deconv_pkg.sv
// Shared constants, width helpers and read-FSM encoding for the deconv weight column buffer.
package deconv_pkg;

  localparam int unsigned DefBitWidth   = 8;
  localparam int unsigned DefKernelSize = 5;
  localparam int unsigned DefNumChnl    = 2;
  localparam int unsigned DefLoopW      = 4;

  localparam int unsigned COL_W     = DefBitWidth * DefKernelSize;
  localparam int unsigned RAM_DEPTH = DefNumChnl * DefKernelSize;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  typedef enum logic [0:0] {
    RWait = 1'b0,
    RRun  = 1'b1
  } rd_state_e;

endpackage

// File: rtl/weight_col_ram.sv
// One-write/one-read column RAM with a registered read port.
// Read data holds its value while re_i is low and clears on reset.
module weight_col_ram #(
  parameter int unsigned Width = deconv_pkg::COL_W,
  parameter int unsigned Depth = deconv_pkg::RAM_DEPTH,
  parameter int unsigned AddrW = deconv_pkg::idx_w(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_col_buffer_mc.sv
// Multi-channel KxK weight buffer: byte-serial column packer, banked column RAM and a read FSM
// that replays each kernel i_loop_cnt times. Define FLIP_KERNEL_EN to export the rotated kernel.
module weight_col_buffer_mc #(
  parameter int unsigned BIT_WIDTH   = deconv_pkg::DefBitWidth,
  parameter int unsigned KERNEL_SIZE = deconv_pkg::DefKernelSize,
  parameter int unsigned NUM_CHNL    = deconv_pkg::DefNumChnl,
  parameter int unsigned LOOP_W      = deconv_pkg::DefLoopW
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_wr_en,
  input  logic [BIT_WIDTH-1:0]                   i_wr_data,
  output logic                                   o_wr_ready,
  output logic                                   o_full,
  output logic                                   o_empty,
  output logic                                   o_wr_err,
  input  logic [LOOP_W-1:0]                      i_loop_cnt,
  input  logic                                   i_rd_col,
  input  logic                                   i_flush,
  output logic [BIT_WIDTH*KERNEL_SIZE-1:0]       o_col_data,
  output logic                                   o_col_valid,
  output logic                                   o_chnl_done,
  output logic [deconv_pkg::idx_w(NUM_CHNL)-1:0] o_chnl_idx
);
  import deconv_pkg::*;

  localparam int unsigned K        = KERNEL_SIZE;
  localparam int unsigned ColW     = BIT_WIDTH * K;
  localparam int unsigned RamDepth = NUM_CHNL * K;
  localparam int unsigned AddrW    = idx_w(RamDepth);
  localparam int unsigned IdxW     = idx_w(NUM_CHNL);
  localparam int unsigned RowW     = idx_w(K);
  localparam int unsigned CntW     = clog2(NUM_CHNL + 1);

  logic [ColW-1:0]     wr_col_q, wr_col_d, col_wdata;
  logic [RowW-1:0]     wr_row_q, wr_row_d, wr_cnum_q, wr_cnum_d;
  logic [IdxW-1:0]     wr_bank_q, wr_bank_d;
  logic                wr_err_q, wr_err_d;
  logic [NUM_CHNL-1:0] loaded_q, loaded_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  rd_state_e           state_q, state_d;
  logic [IdxW-1:0]     rd_bank_q, rd_bank_d;
  logic [RowW-1:0]     rcol_q, rcol_d, rd_phys;
  logic [LOOP_W-1:0]   pass_q, pass_d, passes_q, passes_d, loop_eff, passes_eff;
  logic                col_valid_q, chnl_done_q;

  logic                wr_accept, ram_we, load;
  logic                rd_accept, rd_flush, rd_final, rd_free, first_col, last_col;
  logic [AddrW-1:0]    ram_waddr, ram_raddr;
  logic [ColW-1:0]     ram_rdata;

  // Write packer: word w lands in row w%K of column w/K of the current write bank.
  always_comb begin
    wr_accept = i_wr_en & ~o_full;
    col_wdata = wr_col_q;
    col_wdata[wr_row_q * BIT_WIDTH +: BIT_WIDTH] = i_wr_data;
    ram_we    = wr_accept && (wr_row_q == RowW'(K - 1));
    load      = ram_we && (wr_cnum_q == RowW'(K - 1));
    ram_waddr = AddrW'(wr_bank_q * K + wr_cnum_q);
    wr_col_d  = wr_accept ? col_wdata : wr_col_q;
    wr_row_d  = wr_row_q;
    wr_cnum_d = wr_cnum_q;
    wr_bank_d = wr_bank_q;
    wr_err_d  = wr_err_q | (i_wr_en & o_full);
    if (wr_accept) begin
      wr_row_d = ram_we ? '0 : wr_row_q + RowW'(1);
    end
    if (ram_we) begin
      wr_cnum_d = load ? '0 : wr_cnum_q + RowW'(1);
    end
    if (load) begin
      wr_bank_d = (wr_bank_q == IdxW'(NUM_CHNL - 1)) ? '0 : wr_bank_q + IdxW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RWait;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RWait: if (loaded_q[rd_bank_q]) state_d = RRun;
      RRun:  if (rd_free) state_d = RWait;
    endcase
  end

  always_comb begin
    rd_flush  = (state_q == RRun) && i_flush;
    rd_accept = (state_q == RRun) && i_rd_col && !i_flush;
  end

  // Pass count is taken from i_loop_cnt on the first column of a channel, 0 meaning 1.
  always_comb begin
    first_col  = (rcol_q == '0) && (pass_q == '0);
    last_col   = (rcol_q == RowW'(K - 1));
    loop_eff   = (i_loop_cnt == '0) ? LOOP_W'(1) : i_loop_cnt;
    passes_eff = first_col ? loop_eff : passes_q;
    rd_final   = rd_accept && last_col && (pass_q == passes_eff - LOOP_W'(1));
    rd_free    = rd_flush || rd_final;
`ifdef FLIP_KERNEL_EN
    rd_phys    = RowW'(K - 1) - rcol_q;
`else
    rd_phys    = rcol_q;
`endif
    ram_raddr  = AddrW'(rd_bank_q * K + rd_phys);
    rcol_d     = rcol_q;
    pass_d     = pass_q;
    passes_d   = (rd_accept && first_col) ? loop_eff : passes_q;
    rd_bank_d  = rd_bank_q;
    if (rd_free) begin
      rcol_d    = '0;
      pass_d    = '0;
      rd_bank_d = (rd_bank_q == IdxW'(NUM_CHNL - 1)) ? '0 : rd_bank_q + IdxW'(1);
    end else if (rd_accept) begin
      if (last_col) begin
        rcol_d = '0;
        pass_d = pass_q + LOOP_W'(1);
      end else begin
        rcol_d = rcol_q + RowW'(1);
      end
    end
  end

  // Free and load always target different banks, so both updates apply.
  always_comb begin
    loaded_d = loaded_q;
    if (rd_free) loaded_d[rd_bank_q] = 1'b0;
    if (load) loaded_d[wr_bank_q] = 1'b1;
    cnt_d = cnt_q + CntW'(load) - CntW'(rd_free);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_col_q    <= '0;
      wr_row_q    <= '0;
      wr_cnum_q   <= '0;
      wr_bank_q   <= '0;
      wr_err_q    <= 1'b0;
      loaded_q    <= '0;
      cnt_q       <= '0;
      rd_bank_q   <= '0;
      rcol_q      <= '0;
      pass_q      <= '0;
      passes_q    <= '0;
      col_valid_q <= 1'b0;
      chnl_done_q <= 1'b0;
    end else begin
      wr_col_q    <= wr_col_d;
      wr_row_q    <= wr_row_d;
      wr_cnum_q   <= wr_cnum_d;
      wr_bank_q   <= wr_bank_d;
      wr_err_q    <= wr_err_d;
      loaded_q    <= loaded_d;
      cnt_q       <= cnt_d;
      rd_bank_q   <= rd_bank_d;
      rcol_q      <= rcol_d;
      pass_q      <= pass_d;
      passes_q    <= passes_d;
      col_valid_q <= rd_accept;
      chnl_done_q <= rd_free;
    end
  end

  weight_col_ram #(
    .Width (ColW),
    .Depth (RamDepth),
    .AddrW (AddrW)
  ) u_ram (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (col_wdata),
    .re_i    (rd_accept),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    o_col_data = '0;
`ifdef FLIP_KERNEL_EN
    for (int unsigned r = 0; r < K; r++) begin
      o_col_data[r * BIT_WIDTH +: BIT_WIDTH] = ram_rdata[(K - 1 - r) * BIT_WIDTH +: BIT_WIDTH];
    end
`else
    o_col_data = ram_rdata;
`endif
  end

  assign o_full      = (cnt_q == CntW'(NUM_CHNL));
  assign o_empty     = (cnt_q == '0);
  assign o_wr_ready  = ~o_full;
  assign o_wr_err    = wr_err_q;
  assign o_col_valid = col_valid_q;
  assign o_chnl_done = chnl_done_q;
  assign o_chnl_idx  = rd_bank_q;

endmodule

// File: tb/tb_weight_col_buffer_mc.sv
// Bench for weight_col_buffer_mc: queue-based kernel model checked every cycle, plus literal pins.
module tb_weight_col_buffer_mc;
  localparam int K  = 5;
  localparam int KK = K * K;
  localparam int N  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, wr_en = 1'b0, rd_col = 1'b0, flush = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [3:0]  loop_cnt = 4'd1;
  logic        wr_ready, full, empty, wr_err, col_valid, chnl_done;
  logic [39:0] col_data;
  logic [0:0]  chnl_idx;

  weight_col_buffer_mc dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_en     (wr_en),
    .i_wr_data   (wr_data),
    .o_wr_ready  (wr_ready),
    .o_full      (full),
    .o_empty     (empty),
    .o_wr_err    (wr_err),
    .i_loop_cnt  (loop_cnt),
    .i_rd_col    (rd_col),
    .i_flush     (flush),
    .o_col_data  (col_data),
    .o_col_valid (col_valid),
    .o_chnl_done (chnl_done),
    .o_chnl_idx  (chnl_idx)
  );

  int n_checks = 0, n_errors = 0, n_valid = 0, n_done = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: loaded kernels as a flat byte queue (head kernel is the one being read).
  logic [7:0]  kq[$];
  logic [7:0]  part[$];
  bit          m_ready = 1'b0, m_err = 1'b0, e_valid = 1'b0, e_done = 1'b0, pop, pushk;
  int          m_col = 0, m_pass = 0, m_passes = 1, m_idx = 0, nk;
  logic [39:0] e_data = '0;

  function automatic logic [39:0] col_of(input int c);
    logic [39:0] v;
    v = '0;
    for (int r = 0; r < K; r++) begin
`ifdef FLIP_KERNEL_EN
      v[r*8 +: 8] = kq[(K - 1 - c) * K + (K - 1 - r)];
`else
      v[r*8 +: 8] = kq[c * K + r];
`endif
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      kq.delete();
      part.delete();
      m_ready = 1'b0; m_err = 1'b0; e_valid = 1'b0; e_done = 1'b0; e_data = '0;
      m_col = 0; m_pass = 0; m_idx = 0;
    end else begin
      nk = kq.size() / KK;
      pop = 1'b0; pushk = 1'b0; e_valid = 1'b0; e_done = 1'b0;
      if (wr_en) begin
        if (nk == N) m_err = 1'b1;
        else begin
          part.push_back(wr_data);
          pushk = (part.size() == KK);
        end
      end
      if (m_ready) begin
        if (flush) begin
          pop = 1'b1; e_done = 1'b1;
        end else if (rd_col) begin
          if (m_col == 0 && m_pass == 0) m_passes = (loop_cnt == 0) ? 1 : int'(loop_cnt);
          e_valid = 1'b1;
          e_data  = col_of(m_col);
          m_col++;
          if (m_col == K) begin
            m_col = 0;
            m_pass++;
            if (m_pass == m_passes) begin pop = 1'b1; e_done = 1'b1; end
          end
        end
      end else if (nk > 0) begin
        m_ready = 1'b1;
      end
      if (pop) begin
        for (int i = 0; i < KK; i++) void'(kq.pop_front());
        m_ready = 1'b0; m_col = 0; m_pass = 0; m_idx = (m_idx + 1) % N;
      end
      if (pushk) begin
        for (int i = 0; i < KK; i++) kq.push_back(part[i]);
        part.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("col_valid", 64'(col_valid), 64'(e_valid));
      chk("chnl_done", 64'(chnl_done), 64'(e_done));
      chk("col_data", 64'(col_data), 64'(e_data));
      chk("chnl_idx", 64'(chnl_idx), 64'(m_idx));
      chk("full", 64'(full), 64'(kq.size() == N * KK));
      chk("empty", 64'(empty), 64'(kq.size() == 0));
      chk("wr_ready", 64'(wr_ready), 64'(kq.size() != N * KK));
      chk("wr_err", 64'(wr_err), 64'(m_err));
      if (col_valid) n_valid++;
      if (chnl_done) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr_kernel(input logic [7:0] base);
    for (int i = 0; i < KK; i++) wr_byte(base + 8'(i));
  endtask

  task automatic req();
    rd_col = 1'b1;
    tick();
    rd_col = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; rd_col = 1'b1;
    tick();
    flush = 1'b0; rd_col = 1'b0;
  endtask

  int v0, d0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    chk("rst_col_data", 64'(col_data), 64'h0);
    chk("rst_valid", 64'(col_valid), 64'h0);
    chk("rst_done", 64'(chnl_done), 64'h0);
    chk("rst_empty", 64'(empty), 64'h1);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_idx", 64'(chnl_idx), 64'h0);
    rst = 1'b0;

    // 1: single pass, five back-to-back columns
    loop_cnt = 4'd1;
    wr_kernel(8'd1);
    idle(2);
    req();
`ifdef FLIP_KERNEL_EN
    chk("t1_col0", 64'(col_data), 64'h1516171819);
`else
    chk("t1_col0", 64'(col_data), 64'h0504030201);
`endif
    repeat (4) req();
`ifdef FLIP_KERNEL_EN
    chk("t1_col4", 64'(col_data), 64'h0102030405);
`else
    chk("t1_col4", 64'(col_data), 64'h1918171615);
`endif
    chk("t1_done", 64'(chnl_done), 64'h1);
    chk("t1_empty", 64'(empty), 64'h1);

    // 2: three passes; loop_cnt changed after the first column must not matter
    loop_cnt = 4'd3;
    wr_kernel(8'd26);
    idle(2);
    v0 = n_valid; d0 = n_done;
    req();
    loop_cnt = 4'd1;
    repeat (5) req();
`ifdef FLIP_KERNEL_EN
    chk("t2_rep_col0", 64'(col_data), 64'h2E2F303132);
`else
    chk("t2_rep_col0", 64'(col_data), 64'h1E1D1C1B1A);
`endif
    chk("t2_mid_done", 64'(chnl_done), 64'h0);
    repeat (9) req();
    chk("t2_last_done", 64'(chnl_done), 64'h1);
    idle(1);
    chk("t2_valids", 64'(n_valid - v0), 64'd15);
    chk("t2_dones", 64'(n_done - d0), 64'd1);

    // 3: fill both banks, overflow, free one, refill
    wr_kernel(8'd100);
    wr_kernel(8'd125);
    chk("t3_full", 64'(full), 64'h1);
    chk("t3_not_ready", 64'(wr_ready), 64'h0);
    wr_byte(8'hEE);
    chk("t3_wr_err", 64'(wr_err), 64'h1);
    idle(2);
    repeat (5) req();
    chk("t3_ready_after_free", 64'(wr_ready), 64'h1);
    wr_kernel(8'd200);
    chk("t3_refull", 64'(full), 64'h1);

    // 4: flush bank 1 after two columns; bank 0 follows
    idle(2);
    req();
    req();
    do_flush();
    chk("t4_done", 64'(chnl_done), 64'h1);
    chk("t4_no_valid", 64'(col_valid), 64'h0);
    chk("t4_idx", 64'(chnl_idx), 64'h0);
    idle(2);
    req();
`ifdef FLIP_KERNEL_EN
    chk("t4_next_col0", 64'(col_data), 64'hDCDDDEDFE0);
`else
    chk("t4_next_col0", 64'(col_data), 64'hCCCBCAC9C8);
`endif
    repeat (4) req();
    chk("t4_final_done", 64'(chnl_done), 64'h1);
    chk("t4_empty", 64'(empty), 64'h1);

    // loop_cnt = 0 behaves as one pass
    loop_cnt = 4'd0;
    wr_kernel(8'd50);
    idle(2);
    v0 = n_valid; d0 = n_done;
    repeat (5) req();
    chk("t0_done", 64'(chnl_done), 64'h1);
    idle(1);
    chk("t0_valids", 64'(n_valid - v0), 64'd5);
    chk("t0_dones", 64'(n_done - d0), 64'd1);
    loop_cnt = 4'd1;

    // 5: requests and flush while empty, then reset mid-pass with a partial column
    req();
    chk("t5_empty_req", 64'(col_valid), 64'h0);
    do_flush();
    chk("t5_empty_flush", 64'(chnl_done), 64'h0);
    wr_kernel(8'd1);
    idle(2);
    req();
    req();
    wr_byte(8'h99);
    wr_byte(8'h98);
    wr_byte(8'h97);
    rst = 1'b1; rd_col = 1'b1;
    tick();
    rd_col = 1'b0;
    chk("t5_rst_valid", 64'(col_valid), 64'h0);
    chk("t5_rst_data", 64'(col_data), 64'h0);
    chk("t5_rst_empty", 64'(empty), 64'h1);
    chk("t5_rst_err", 64'(wr_err), 64'h0);
    chk("t5_rst_idx", 64'(chnl_idx), 64'h0);
    rst = 1'b0;
    wr_kernel(8'd1);
    idle(2);
    req();
`ifdef FLIP_KERNEL_EN
    chk("t5_fresh_col0", 64'(col_data), 64'h1516171819);
`else
    chk("t5_fresh_col0", 64'(col_data), 64'h0504030201);
`endif
    repeat (4) req();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
